// File: rtl/reorder_buffer.sv
// Reorder buffer for the Tomasulo core.
// Issue allocates entries in program order and hands out the tail index as the
// ROB tag. Execution results arrive on the CDB by tag. The head entry retires
// once it is ready, producing a register write, a memory write or a pipeline
// flush as a registered one-cycle pulse on the following cycle.
module reorder_buffer #(
    parameter int DEPTH = 8,
    parameter int DW    = 16
) (
    input  logic                         clk1,
    input  logic                         rst_n,
    input  logic                         alloc_valid,
    input  logic [3:0]                   alloc_func,
    input  logic [7:0]                   alloc_dest,
    output logic                         alloc_ready,
    output logic [$clog2(DEPTH)-1:0]     alloc_tag,
    input  logic                         cdb_valid,
    input  logic [$clog2(DEPTH)-1:0]     cdb_tag,
    input  logic [DW-1:0]                cdb_value,
    input  logic                         cdb_taken,
    output logic                         commit_valid,
    output logic [3:0]                   commit_rd,
    output logic [DW-1:0]                commit_value,
    output logic [$clog2(DEPTH)-1:0]     commit_tag,
    output logic                         mem_we,
    output logic [7:0]                   mem_addr,
    output logic [DW-1:0]                mem_wdata,
    output logic                         flush,
    output logic [3:0]                   flush_target,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        KIND_REG    = 2'd0,
        KIND_STORE  = 2'd1,
        KIND_BRANCH = 2'd2,
        KIND_NOP    = 2'd3
    } kind_e;

    // Map an issue opcode onto the retirement action it needs.
    function automatic kind_e decode_kind(input logic [3:0] func);
        kind_e k;
        case (func)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100: k = KIND_REG;
            4'b0101:                                     k = KIND_STORE;
            4'b0110, 4'b0111:                            k = KIND_BRANCH;
            default:                                     k = KIND_NOP;
        endcase
        return k;
    endfunction

    // Entry storage
    logic [DEPTH-1:0] busy_q,  busy_d;
    logic [DEPTH-1:0] ready_q, ready_d;
    logic [DEPTH-1:0] taken_q, taken_d;
    kind_e            kind_q  [DEPTH];
    kind_e            kind_d  [DEPTH];
    logic [7:0]       dest_q  [DEPTH];
    logic [7:0]       dest_d  [DEPTH];
    logic [DW-1:0]    value_q [DEPTH];
    logic [DW-1:0]    value_d [DEPTH];

    // Pointers and occupancy
    logic [AW-1:0] head_q,  head_d;
    logic [AW-1:0] tail_q,  tail_d;
    logic [CW-1:0] count_q, count_d;

    // Registered retirement outputs
    logic          commit_valid_q, commit_valid_d;
    logic [3:0]    commit_rd_q,    commit_rd_d;
    logic [DW-1:0] commit_value_q, commit_value_d;
    logic [AW-1:0] commit_tag_q,   commit_tag_d;
    logic          mem_we_q,       mem_we_d;
    logic [7:0]    mem_addr_q,     mem_addr_d;
    logic [DW-1:0] mem_wdata_q,    mem_wdata_d;
    logic          flush_q,        flush_d;
    logic [3:0]    flush_target_q, flush_target_d;

    // Control decode
    logic          head_commit_s;
    logic          flush_now_s;
    logic          alloc_fire_s;
    logic          cdb_hit_s;
    kind_e         head_kind_s;
    kind_e         alloc_kind_s;
    logic [7:0]    head_dest_s;
    logic [DW-1:0] head_value_s;

    assign head_kind_s   = kind_q[head_q];
    assign head_dest_s   = dest_q[head_q];
    assign head_value_s  = value_q[head_q];
    assign alloc_kind_s  = decode_kind(alloc_func);
    assign head_commit_s = busy_q[head_q] & ready_q[head_q];
    // A retiring taken branch wipes the buffer, so issue is held off that cycle.
    assign flush_now_s   = head_commit_s && (head_kind_s == KIND_BRANCH) && taken_q[head_q];
    // No full-bypass: a same-cycle commit does not free room for a full buffer.
    assign alloc_ready   = (count_q < CNT_FULL) && !flush_now_s;
    assign alloc_fire_s  = alloc_valid && alloc_ready;
    // Stale tags and repeat broadcasts to an already-ready entry are dropped.
    assign cdb_hit_s     = cdb_valid && busy_q[cdb_tag] && !ready_q[cdb_tag];

    assign alloc_tag     = tail_q;
    assign count         = count_q;
    assign empty         = (count_q == CNT_ZERO);
    assign commit_valid  = commit_valid_q;
    assign commit_rd     = commit_rd_q;
    assign commit_value  = commit_value_q;
    assign commit_tag    = commit_tag_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign flush         = flush_q;
    assign flush_target  = flush_target_q;

    // Per-entry next state: flush clears all, otherwise allocate, CDB write or retire.
    always_comb begin
        busy_d  = busy_q;
        ready_d = ready_q;
        taken_d = taken_q;
        kind_d  = kind_q;
        dest_d  = dest_q;
        value_d = value_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush_now_s) begin
                busy_d[i]  = 1'b0;
                ready_d[i] = 1'b0;
            end else if (alloc_fire_s && (tail_q == AW'(i))) begin
                busy_d[i]  = 1'b1;
                ready_d[i] = (alloc_kind_s == KIND_NOP);
                kind_d[i]  = alloc_kind_s;
                dest_d[i]  = alloc_dest;
                value_d[i] = {DW{1'b0}};
                taken_d[i] = 1'b0;
            end else if (cdb_hit_s && (cdb_tag == AW'(i))) begin
                ready_d[i] = 1'b1;
                value_d[i] = cdb_value;
                taken_d[i] = cdb_taken;
            end else if (head_commit_s && (head_q == AW'(i))) begin
                busy_d[i]  = 1'b0;
                ready_d[i] = 1'b0;
            end else begin
                busy_d[i]  = busy_q[i];
                ready_d[i] = ready_q[i];
            end
        end
    end

    // Pointer and occupancy next state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_now_s) begin
            head_d  = PTR_ZERO;
            tail_d  = PTR_ZERO;
            count_d = CNT_ZERO;
        end else begin
            head_d = head_commit_s ? (head_q + PTR_ONE) : head_q;
            tail_d = alloc_fire_s  ? (tail_q + PTR_ONE) : tail_q;
            case ({alloc_fire_s, head_commit_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Retirement output next state; data fields hold while their pulse is low.
    always_comb begin
        commit_valid_d = head_commit_s && (head_kind_s == KIND_REG);
        mem_we_d       = head_commit_s && (head_kind_s == KIND_STORE);
        flush_d        = flush_now_s;
        commit_rd_d    = commit_valid_d ? head_dest_s[3:0] : commit_rd_q;
        commit_value_d = commit_valid_d ? head_value_s     : commit_value_q;
        commit_tag_d   = commit_valid_d ? head_q           : commit_tag_q;
        mem_addr_d     = mem_we_d       ? head_dest_s      : mem_addr_q;
        mem_wdata_d    = mem_we_d       ? head_value_s     : mem_wdata_q;
        flush_target_d = flush_d        ? head_dest_s[3:0] : flush_target_q;
    end

    // Entry storage registers.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= {DEPTH{1'b0}};
            ready_q <= {DEPTH{1'b0}};
            taken_q <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                kind_q[i]  <= KIND_NOP;
                dest_q[i]  <= 8'h00;
                value_q[i] <= {DW{1'b0}};
            end
        end else begin
            busy_q  <= busy_d;
            ready_q <= ready_d;
            taken_q <= taken_d;
            kind_q  <= kind_d;
            dest_q  <= dest_d;
            value_q <= value_d;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= PTR_ZERO;
            tail_q  <= PTR_ZERO;
            count_q <= CNT_ZERO;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Retirement output registers.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid_q <= 1'b0;
            commit_rd_q    <= 4'h0;
            commit_value_q <= {DW{1'b0}};
            commit_tag_q   <= PTR_ZERO;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 8'h00;
            mem_wdata_q    <= {DW{1'b0}};
            flush_q        <= 1'b0;
            flush_target_q <= 4'h0;
        end else begin
            commit_valid_q <= commit_valid_d;
            commit_rd_q    <= commit_rd_d;
            commit_value_q <= commit_value_d;
            commit_tag_q   <= commit_tag_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            flush_q        <= flush_d;
            flush_target_q <= flush_target_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: retirement pulses are checked against
// a scoreboard of expected events, plus inline checks of flags and timing.
module tb_reorder_buffer;

    localparam logic [3:0] F_ADD   = 4'b0000;
    localparam logic [3:0] F_MUL   = 4'b0010;
    localparam logic [3:0] F_STORE = 4'b0101;
    localparam logic [3:0] F_BEQ   = 4'b0110;
    localparam logic [3:0] F_BNEQ  = 4'b0111;
    localparam int EV_REG   = 0;
    localparam int EV_MEM   = 1;
    localparam int EV_FLUSH = 2;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        alloc_valid = 1'b0;
    logic [3:0]  alloc_func = 4'h0;
    logic [7:0]  alloc_dest = 8'h00;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        cdb_valid = 1'b0;
    logic [2:0]  cdb_tag = 3'd0;
    logic [15:0] cdb_value = 16'h0000;
    logic        cdb_taken = 1'b0;
    logic        commit_valid;
    logic [3:0]  commit_rd;
    logic [15:0] commit_value;
    logic [2:0]  commit_tag;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        flush;
    logic [3:0]  flush_target;
    logic [3:0]  count;
    logic        empty;

    typedef struct {
        int          ev;
        logic [7:0]  a;
        logic [15:0] v;
        logic [2:0]  tag;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    logic [2:0] model_tail = 3'd0;

    reorder_buffer #(.DEPTH(8), .DW(16)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_dest(alloc_dest),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_tag(commit_tag), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .flush(flush), .flush_target(flush_target), .count(count), .empty(empty)
    );

    initial forever #5 clk1 = ~clk1;

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic push_exp(input int ev, input logic [7:0] a, input logic [15:0] v, input logic [2:0] tag);
        exp_t e;
        e.ev = ev; e.a = a; e.v = v; e.tag = tag;
        sb.push_back(e);
    endtask

    // Pops the scoreboard whenever a retirement pulse is visible.
    task automatic scoreboard_monitor();
        exp_t e;
        int   np;
        forever begin
            @(negedge clk1);
            if (rst_n === 1'b1) begin
                np = int'(commit_valid) + int'(mem_we) + int'(flush);
                if (np > 1) begin
                    tests++; fails++;
                    $display("FAIL multi_pulse: got cv=%b we=%b fl=%b required at most one", commit_valid, mem_we, flush);
                end else if (np == 1) begin
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_pulse: got cv=%b we=%b fl=%b rd=%h val=%h required none", commit_valid, mem_we, flush, commit_rd, commit_value);
                    end else begin
                        e = sb.pop_front();
                        if (e.ev == EV_REG) begin
                            if (!(commit_valid === 1'b1 && commit_rd === e.a[3:0] && commit_value === e.v && commit_tag === e.tag)) begin
                                fails++;
                                $display("FAIL sb_reg: got cv=%b rd=%h val=%h tag=%0d required rd=%h val=%h tag=%0d", commit_valid, commit_rd, commit_value, commit_tag, e.a[3:0], e.v, e.tag);
                            end
                        end else if (e.ev == EV_MEM) begin
                            if (!(mem_we === 1'b1 && mem_addr === e.a && mem_wdata === e.v)) begin
                                fails++;
                                $display("FAIL sb_mem: got we=%b addr=%h data=%h required addr=%h data=%h", mem_we, mem_addr, mem_wdata, e.a, e.v);
                            end
                        end else begin
                            if (!(flush === 1'b1 && flush_target === e.a[3:0])) begin
                                fails++;
                                $display("FAIL sb_flush: got fl=%b target=%h required target=%h", flush, flush_target, e.a[3:0]);
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; alloc_valid = 1'b0; cdb_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        sb.delete();
        model_tail = 3'd0;
    endtask

    task automatic alloc(input logic [3:0] f, input logic [7:0] d);
        alloc_valid = 1'b1; alloc_func = f; alloc_dest = d;
        tests++;
        if (alloc_ready !== 1'b1 || alloc_tag !== model_tail) begin
            fails++;
            $display("FAIL alloc_handshake: got ready=%b tag=%0d required ready=1 tag=%0d", alloc_ready, alloc_tag, model_tail);
        end
        step();
        alloc_valid = 1'b0;
        model_tail = model_tail + 3'd1;
    endtask

    task automatic cdb(input logic [2:0] t, input logic [15:0] v, input logic tk);
        cdb_valid = 1'b1; cdb_tag = t; cdb_value = v; cdb_taken = tk;
        step();
        cdb_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 60) begin
            step(); k++;
        end
        step();
        tests++;
        if (sb.size() != 0 || count !== 4'd0) begin
            fails++;
            $display("FAIL %s_drain: got pending=%0d count=%0d required 0/0", name, sb.size(), count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests++;
        if (count !== 4'd0 || empty !== 1'b1 || alloc_ready !== 1'b1 || alloc_tag !== 3'd0 ||
            commit_valid !== 1'b0 || mem_we !== 1'b0 || flush !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got cnt=%0d emp=%b rdy=%b tag=%0d cv=%b we=%b fl=%b required 0 1 1 0 0 0 0",
                     count, empty, alloc_ready, alloc_tag, commit_valid, mem_we, flush);
        end
        do_reset();
    endtask

    task automatic test_in_order();
        alloc(F_ADD, 8'h03);
        alloc(F_MUL, 8'h05);
        cdb(3'd1, 16'h0020, 1'b0);
        step(); step(); step();
        tests++;
        if (count !== 4'd2) begin
            fails++;
            $display("FAIL inorder_hold: got count=%0d required 2", count);
        end
        push_exp(EV_REG, 8'h03, 16'h0007, 3'd0);
        push_exp(EV_REG, 8'h05, 16'h0020, 3'd1);
        cdb(3'd0, 16'h0007, 1'b0);
        tests++;
        if (commit_valid !== 1'b0) begin
            fails++;
            $display("FAIL inorder_same_edge: got cv=%b required 0", commit_valid);
        end
        step();
        tests++;
        if (commit_valid !== 1'b1 || commit_rd !== 4'd3 || commit_value !== 16'h0007) begin
            fails++;
            $display("FAIL inorder_first: got cv=%b rd=%h val=%h required 1 3 0007", commit_valid, commit_rd, commit_value);
        end
        step();
        tests++;
        if (commit_valid !== 1'b1 || commit_rd !== 4'd5 || commit_value !== 16'h0020) begin
            fails++;
            $display("FAIL inorder_second: got cv=%b rd=%h val=%h required 1 5 0020", commit_valid, commit_rd, commit_value);
        end
        drain("inorder");
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) alloc(F_ADD, 8'(i));
        tests++;
        if (alloc_ready !== 1'b0 || count !== 4'd8 || empty !== 1'b0) begin
            fails++;
            $display("FAIL full_flags: got rdy=%b count=%0d emp=%b required 0 8 0", alloc_ready, count, empty);
        end
        alloc_valid = 1'b1; alloc_func = F_ADD; alloc_dest = 8'h09;
        push_exp(EV_REG, 8'h00, 16'h0100, 3'd0);
        cdb(3'd0, 16'h0100, 1'b0);
        tests++;
        if (alloc_ready !== 1'b0 || count !== 4'd8) begin
            fails++;
            $display("FAIL full_no_bypass: got rdy=%b count=%0d required 0 8", alloc_ready, count);
        end
        step();
        tests++;
        if (count !== 4'd7 || alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin
            fails++;
            $display("FAIL full_after_retire: got count=%0d rdy=%b tag=%0d required 7 1 0", count, alloc_ready, alloc_tag);
        end
        step();
        alloc_valid = 1'b0;
        model_tail = 3'd1;
        tests++;
        if (count !== 4'd8 || alloc_tag !== 3'd1) begin
            fails++;
            $display("FAIL full_wrap_alloc: got count=%0d tag=%0d required 8 1", count, alloc_tag);
        end
        for (int t = 1; t < 8; t++) begin
            push_exp(EV_REG, 8'(t), 16'h0100 + 16'(t), 3'(t));
            cdb(3'(t), 16'h0100 + 16'(t), 1'b0);
        end
        push_exp(EV_REG, 8'h09, 16'h0999, 3'd0);
        cdb(3'd0, 16'h0999, 1'b0);
        drain("full");
    endtask

    task automatic test_store();
        logic [2:0] t;
        t = model_tail;
        alloc(F_STORE, 8'hA5);
        push_exp(EV_MEM, 8'hA5, 16'h1234, t);
        cdb(t, 16'h1234, 1'b1);
        drain("store");
    endtask

    task automatic test_branch(input logic tk);
        logic [2:0] t0;
        t0 = model_tail;
        alloc(tk ? F_BEQ : F_BNEQ, 8'h09);
        for (int i = 1; i <= 3; i++) alloc(F_ADD, 8'(i));
        for (int i = 1; i <= 3; i++) cdb(t0 + 3'(i), 16'h0A00 + 16'(i), 1'b1);
        tests++;
        if (count !== 4'd4) begin
            fails++;
            $display("FAIL branch_pending: got count=%0d required 4", count);
        end
        if (tk) push_exp(EV_FLUSH, 8'h09, 16'h0000, t0);
        else for (int i = 1; i <= 3; i++) push_exp(EV_REG, 8'(i), 16'h0A00 + 16'(i), t0 + 3'(i));
        cdb(t0, 16'h0000, tk);
        if (tk) begin
            tests++;
            if (alloc_ready !== 1'b0) begin
                fails++;
                $display("FAIL flush_blocks_alloc: got rdy=%b required 0", alloc_ready);
            end
            step();
            model_tail = 3'd0;
            tests++;
            if (flush !== 1'b1 || flush_target !== 4'd9 || count !== 4'd0 || empty !== 1'b1 || alloc_tag !== 3'd0) begin
                fails++;
                $display("FAIL flush_state: got fl=%b tgt=%h count=%0d emp=%b tag=%0d required 1 9 0 1 0",
                         flush, flush_target, count, empty, alloc_tag);
            end
            step(); step(); step();
        end
        drain(tk ? "branch_taken" : "branch_not_taken");
    endtask

    task automatic test_nop();
        logic [2:0] t;
        alloc(4'b1000, 8'h0E);
        alloc(4'b1111, 8'h0F);
        t = model_tail;
        alloc(F_ADD, 8'h0C);
        push_exp(EV_REG, 8'h0C, 16'h00CC, t);
        cdb(t, 16'h00CC, 1'b0);
        drain("nop");
    endtask

    task automatic test_stale_cdb();
        do_reset();
        for (int i = 0; i < 4; i++) alloc(F_ADD, 8'(i));
        cdb(3'd4, 16'hBEEF, 1'b0);
        tests++;
        if (count !== 4'd4) begin
            fails++;
            $display("FAIL stale_count: got count=%0d required 4", count);
        end
        alloc(F_ADD, 8'h07);
        for (int i = 0; i < 4; i++) begin
            push_exp(EV_REG, 8'(i), 16'h0010 + 16'(i), 3'(i));
            cdb(3'(i), 16'h0010 + 16'(i), 1'b0);
        end
        step(); step(); step(); step();
        tests++;
        if (count !== 4'd1 || sb.size() != 0) begin
            fails++;
            $display("FAIL stale_not_ready: got count=%0d pending=%0d required 1 0", count, sb.size());
        end
        push_exp(EV_REG, 8'h07, 16'h0044, 3'd4);
        cdb(3'd4, 16'h0044, 1'b0);
        drain("stale");
    endtask

    task automatic test_reset_midstream();
        logic [2:0] t0;
        t0 = model_tail;
        for (int i = 0; i < 5; i++) alloc(F_ADD, 8'(i + 1));
        for (int i = 1; i < 5; i++) cdb(t0 + 3'(i), 16'h0055, 1'b0);
        rst_n = 1'b0;
        #1;
        tests++;
        if (count !== 4'd0 || empty !== 1'b1 || alloc_ready !== 1'b1 ||
            commit_valid !== 1'b0 || mem_we !== 1'b0 || flush !== 1'b0) begin
            fails++;
            $display("FAIL midreset_state: got cnt=%0d emp=%b rdy=%b cv=%b we=%b fl=%b required 0 1 1 0 0 0",
                     count, empty, alloc_ready, commit_valid, mem_we, flush);
        end
        step();
        rst_n = 1'b1;
        sb.delete();
        model_tail = 3'd0;
        step();
        tests++;
        if (alloc_tag !== 3'd0 || count !== 4'd0) begin
            fails++;
            $display("FAIL midreset_release: got tag=%0d count=%0d required 0 0", alloc_tag, count);
        end
        alloc(F_ADD, 8'h02);
        push_exp(EV_REG, 8'h02, 16'h2222, 3'd0);
        cdb(3'd0, 16'h2222, 1'b0);
        drain("midreset");
    endtask

    initial begin
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_in_order();
        test_full_wrap();
        test_store();
        test_branch(1'b1);
        test_branch(1'b0);
        test_nop();
        test_stale_cdb();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- 8-entry in-order reorder buffer, directly downstream of the issue/reservation-station stage of the Tomasulo core.
- Issue allocates one entry per decoded instruction and receives a 3-bit ROB tag. The execution units later broadcast results on the CDB by tag.
- Entries retire strictly in program order from the head, producing:
  - register-bank writes (ALU ops and load),
  - memory writes (store),
  - a pipeline flush (taken branch).

Parameters:
- DEPTH, 8, number of entries; must be a power of two; tag width = log2(DEPTH) = 3.
- DW, 16, data width of results, register values and memory words.

Ports:
- clk1  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alloc_valid  in  1  issue requests an entry this cycle.
- alloc_func  in  4  opcode: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 load, 0101 store, 0110 beq, 0111 bneq.
- alloc_dest  in  8  meaning depends on opcode:
  - [3:0] = rd for ALU ops and load,
  - full 8 bits = memory address for store,
  - [3:0] = branch imm for beq/bneq.
- alloc_ready  out  1  entry available; the request is accepted when alloc_valid and alloc_ready are both high.
- alloc_tag  out  3  tag the next accepted request receives (equals tail pointer).
- cdb_valid  in  1  result broadcast this cycle.
- cdb_tag  in  3  ROB tag of the broadcast result.
- cdb_value  in  16  result value, or store data for a store.
- cdb_taken  in  1  branch outcome (1 = taken); ignored for non-branch entries.
- commit_valid  out  1  registered one-cycle pulse: register write.
- commit_rd  out  4  destination register for the write.
- commit_value  out  16  value to write.
- commit_tag  out  3  tag of the retired entry, so the register bank can clear its ROB link.
- mem_we  out  1  registered one-cycle pulse: store retired.
- mem_addr  out  8  store address.
- mem_wdata  out  16  store data.
- flush  out  1  registered one-cycle pulse: taken branch retired.
- flush_target  out  4  branch imm to be loaded into the PC.
- count  out  4  occupied entries, 0..8.
- empty  out  1  count == 0.

Behaviour:
- Per-entry state: busy, ready, kind, dest[7:0], value[15:0], taken.
  - kind is one of REG, STORE, BRANCH, NOP.
  - Pointers head[2:0] and tail[2:0] both wrap 7 -> 0.
- Reset (asynchronous, rst_n low):
  - all entries are cleared to busy=0, ready=0;
  - head = tail = 0 and count = 0;
  - every output pulse and data output is 0; empty = 1, alloc_ready = 1.
  - A reset asserted mid-operation discards all in-flight entries with no side effects.
- Allocate, on an edge where alloc_valid && alloc_ready:
  - the entry at tail is set to busy=1 and its kind is decoded from alloc_func;
  - dest is loaded from alloc_dest, and tail increments;
  - ready is set to 0, except opcodes 1000-1111 become kind NOP with ready=1 (they retire with no side effect).
- alloc_ready = (count < 8) && !flush_now.
  - flush_now is combinational: head is busy, ready, kind BRANCH and taken.
  - No full-bypass: a commit in the same cycle does not make room for an allocation into a full buffer.
- CDB, on an edge where cdb_valid is high:
  - if entry[cdb_tag] is busy and not yet ready, it takes value = cdb_value, taken = cdb_taken, ready = 1;
  - otherwise the broadcast is ignored (stale tag, or already ready).
- Commit, on an edge where the head entry is busy && ready:
  - the entry is freed, head increments and count decrements, all at that edge;
  - exactly one entry retires per cycle;
  - the output pulse appears in the following cycle:
    - REG: commit_valid = 1, commit_rd = dest[3:0], commit_value, commit_tag;
    - STORE: mem_we = 1, mem_addr = dest, mem_wdata = value;
    - BRANCH not taken: no pulse;
    - BRANCH taken: flush = 1, flush_target = dest[3:0], and every entry is cleared, with head = tail = count = 0 at that edge;
    - NOP: no pulse.
- Data outputs hold their last value while their pulse is low.
- Latency:
  - the allocate edge is N;
  - the earliest CDB write is edge N+1;
  - the earliest commit edge is N+2, with its pulse visible during cycle N+2..N+3.
  - A CDB write to the head entry commits on the next edge, never the same edge.
- Simultaneous allocate and commit: count is unchanged, and both pointers advance.
- Simultaneous allocate and flush cannot occur, because alloc_ready is low while flush_now is high.

Test Plan:
- Reset:
  - Stimulus: assert rst_n low mid-stream with 5 entries busy.
  - Required: count = 0, empty = 1, alloc_ready = 1, all pulses 0. After release, alloc_tag = 0.
- In-order retire:
  - Stimulus: allocate add rd=3 (tag 0) and mul rd=5 (tag 1); CDB tag 1 = 0x0020 first, then tag 0 = 0x0007.
  - Required: commit_valid pulses rd=3/0x0007, then rd=5/0x0020, on consecutive cycles; nothing commits before tag 0 is ready.
- Full and wrap-around:
  - Stimulus: allocate 8 entries.
  - Required: alloc_ready = 0 and count = 8. After retiring the head, alloc_ready = 1 and the next alloc_tag = 0 (wrapped).
- Store:
  - Stimulus: allocate store dest=0xA5; CDB value 0x1234.
  - Required: mem_we pulses once with mem_addr = 0xA5 and mem_wdata = 0x1234; commit_valid stays 0.
- Branch flush:
  - Stimulus: allocate beq imm=9, then 3 ALU entries all CDB-ready; CDB the branch taken=1.
  - Required: flush pulses with flush_target = 9, count becomes 0, and no commit_valid occurs for the younger entries.
  - Repeat with taken=0: no flush, and the younger entries retire normally.
- Stale CDB:
  - Stimulus: broadcast cdb_tag = 4 while entry 4 is not busy.
  - Required: state is unchanged, and a later allocation to tag 4 starts with ready = 0.
